// File: rtl/regs_sd_pkg.sv
// Shared defaults and handshake state type for the regs_sd register file.
package regs_sd_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_REG_COUNT  = 28;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } regs_sd_state_e;

endpackage

// File: rtl/regs_sd.sv
// Register file behind a 4-phase req/ack handshake; one access per req pulse,
// registered read data, out-of-range addresses acknowledged but inert.
module regs_sd
  import regs_sd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_COUNT  = DEF_REG_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ack,
  input  logic                  req
);

  regs_sd_state_e                        state_q, state_d;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
  logic [DATA_WIDTH-1:0]                 dout_q, dout_d;
  logic                                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0]                 rd_data;

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    dout_d  = dout_q;
    rd_data = '0;

    // Unmatched (invalid) addresses fall through to zero read data.
    for (int i = 0; i < REG_COUNT; i++)
      if (addr == ADDR_WIDTH'(i)) rd_data = regs_q[i];

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACK;
          if (rw) begin
            for (int i = 0; i < REG_COUNT; i++)
              if (addr == ADDR_WIDTH'(i)) regs_d[i] = data_in;
          end else begin
            dout_d = rd_data;
          end
        end
      end
      ACK: begin
        // Inputs are ignored here; only req falling releases the handshake.
        if (!req) state_d = IDLE;
      end
    endcase

    ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      regs_q  <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
    end
  end

  assign data_out = dout_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_regs_sd.sv
// Randomized self-checking bench for regs_sd against an array-based reference model.
module tb_regs_sd;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RC = 28;

  logic          clk;
  logic          reset;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          ack;
  logic          req;

  int n_chk;
  int n_err;

  logic [DW-1:0] mem [RC];
  logic [DW-1:0] exp_dout;

  regs_sd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC)) dut (
    .clk      (clk),
    .reset    (reset),
    .rw       (rw),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .req      (req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < RC; i++) mem[i] = '0;
    exp_dout = '0;
  endtask

  // One full handshake, starting and ending at a negedge with req low.
  // hold = extra cycles req stays high while rw/addr/data_in wander.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int hold);
    rw = w; addr = a; data_in = d; req = 1'b1;
    if (w) begin
      if (int'(a) < RC) mem[a] = d;
    end else begin
      exp_dout = (int'(a) < RC) ? mem[a] : '0;
    end
    @(negedge clk);
    chk("ack_rise", DW'(ack), DW'(1'b1));
    chk(w ? "wr_dout_hold" : "rd_data", data_out, exp_dout);
    for (int k = 0; k < hold; k++) begin
      rw = 1'($urandom); addr = AW'($urandom); data_in = $urandom;
      @(negedge clk);
      chk("ack_held", DW'(ack), DW'(1'b1));
      chk("dout_held", data_out, exp_dout);
    end
    req = 1'b0;
    @(negedge clk);
    chk("ack_fall", DW'(ack), DW'(1'b0));
    chk("dout_idle", data_out, exp_dout);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; data_in = '0;
    model_clear();

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    chk("rst_ack", DW'(ack), DW'(1'b0));
    chk("rst_dout", data_out, '0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < RC; i++) xfer(1'b0, AW'(i), '0, 0);

    // Write then read
    xfer(1'b1, AW'(5), 32'hDEADBEEF, 0);
    xfer(1'b0, AW'(5), '0, 0);
    chk("wr_rd_5", data_out, 32'hDEADBEEF);

    // Full sweep
    for (int i = 0; i < RC; i++) xfer(1'b1, AW'(i), 32'hA5A50000 + i, 0);
    for (int i = 0; i < RC; i++) begin
      xfer(1'b0, AW'(i), '0, 0);
      chk("sweep", data_out, 32'hA5A50000 + i);
    end

    // Invalid address
    xfer(1'b1, AW'(30), 32'h12345678, 0);
    xfer(1'b0, AW'(30), '0, 0);
    chk("inv_rd", data_out, '0);
    xfer(1'b0, AW'(31), '0, 1);
    for (int i = 0; i < RC; i++) xfer(1'b0, AW'(i), '0, 0);

    // Held request: only the first-sampled write lands
    xfer(1'b1, AW'(3), 32'h0BADF00D, 10);
    xfer(1'b0, AW'(3), '0, 0);
    chk("held_wr", data_out, 32'h0BADF00D);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic          w;
      logic [AW-1:0] a;
      w = 1'($urandom);
      a = AW'($urandom);
      xfer(w, a, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    // Reset mid-transfer drops ack at once and clears the completed write
    rw = 1'b1; addr = AW'(7); data_in = 32'hFFFFFFFF; req = 1'b1;
    @(negedge clk);
    chk("mid_ack_pre", DW'(ack), DW'(1'b1));
    reset = 1'b0;
    #1;
    chk("mid_ack_async", DW'(ack), DW'(1'b0));
    chk("mid_dout_async", data_out, '0);
    req = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", DW'(ack), DW'(1'b0));
    xfer(1'b0, AW'(7), '0, 0);
    chk("post_rst_rd7", data_out, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
